// File: rtl/hilo_mdu.sv
// HI/LO multiply/divide unit for the E stage of the pipelined MIPS core.
// Results are computed at the accepting edge and committed after a fixed latency.
module hilo_mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic        req_block,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        hilo_sel,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] hilo_out
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        commit_q;
    logic [31:0] res_hi_q;
    logic [31:0] res_lo_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        accept;
    logic [63:0] prod_s_d;
    logic [63:0] prod_u_d;
    logic        signed_div;
    logic [31:0] dvd_mag;
    logic [31:0] dvs_mag;
    logic [31:0] quo_mag;
    logic [31:0] rem_mag;
    logic [31:0] quo_d;
    logic [31:0] rem_d;

    assign accept = start & ~req_block & (state_q == IDLE);

    // One magnitude divider serves both DIV and DIVU; signs are restored afterwards.
    // A zero divisor is replaced by 1 so the divider never sees 0; that result is never committed.
    always_comb begin
        prod_s_d   = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        prod_u_d   = {32'd0, A} * {32'd0, B};
        signed_div = (md_op == OP_DIV);
        dvd_mag    = (signed_div && A[31]) ? -A : A;
        dvs_mag    = (signed_div && B[31]) ? -B : B;
        if (dvs_mag == 32'd0) begin
            dvs_mag = 32'd1;
        end
        quo_mag = dvd_mag / dvs_mag;
        rem_mag = dvd_mag % dvs_mag;
        quo_d   = (signed_div && (A[31] ^ B[31])) ? -quo_mag : quo_mag;
        rem_d   = (signed_div && A[31]) ? -rem_mag : rem_mag;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            commit_q <= 1'b0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        case (md_op)
                            OP_MULT: begin
                                {res_hi_q, res_lo_q} <= prod_s_d;
                                cnt_q    <= 4'(MULT_CYCLES);
                                commit_q <= 1'b1;
                                state_q  <= RUN;
                            end
                            OP_MULTU: begin
                                {res_hi_q, res_lo_q} <= prod_u_d;
                                cnt_q    <= 4'(MULT_CYCLES);
                                commit_q <= 1'b1;
                                state_q  <= RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                res_hi_q <= rem_d;
                                res_lo_q <= quo_d;
                                cnt_q    <= 4'(DIV_CYCLES);
                                commit_q <= (B != 32'd0);
                                state_q  <= RUN;
                            end
                            OP_MTHI: hi_q <= A;
                            OP_MTLO: lo_q <= A;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    // Counter hits zero on this edge: commit and release the pipeline.
                    if (cnt_q == 4'd1) begin
                        cnt_q   <= 4'd0;
                        state_q <= IDLE;
                        if (commit_q) begin
                            hi_q <= res_hi_q;
                            lo_q <= res_lo_q;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = (state_q == RUN);
    assign HI       = hi_q;
    assign LO       = lo_q;
    assign hilo_out = hilo_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_hilo_mdu.sv
// Self-checking bench for hilo_mdu: directed plan vectors plus randomized
// operations against an arithmetic reference model of HI/LO.
module tb_hilo_mdu;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic        req_block;
    logic [31:0] A;
    logic [31:0] B;
    logic        hilo_sel;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] hilo_out;

    int          checks;
    int          failures;
    logic [31:0] expHi;
    logic [31:0] expLo;

    hilo_mdu #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .req_block(req_block),
        .A        (A),
        .B        (B),
        .hilo_sel (hilo_sel),
        .busy     (busy),
        .HI       (HI),
        .LO       (LO),
        .hilo_out (hilo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: applies one accepted op to expHi/expLo, returns busy latency.
    function automatic int modelApply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: begin
                p = sa * sb;
                expHi = p[63:32];
                expLo = p[31:0];
                return MULT_N;
            end
            3'd1: begin
                p = {32'd0, a} * {32'd0, b};
                expHi = p[63:32];
                expLo = p[31:0];
                return MULT_N;
            end
            3'd2: begin
                if (b != 0) begin
                    q = sa / sb;
                    r = sa % sb;
                    expLo = q[31:0];
                    expHi = r[31:0];
                end
                return DIV_N;
            end
            3'd3: begin
                if (b != 0) begin
                    expLo = a / b;
                    expHi = a % b;
                end
                return DIV_N;
            end
            3'd4: begin
                expHi = a;
                return 0;
            end
            3'd5: begin
                expLo = a;
                return 0;
            end
            default: return 0;
        endcase
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start     = 1'b1;
        md_op     = op;
        A         = a;
        B         = b;
        req_block = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset     = 1'b0;
        start     = 1'b0;
        md_op     = 3'd0;
        req_block = 1'b0;
        A         = 32'd0;
        B         = 32'd0;
        hilo_sel  = 1'b0;
        expHi     = 32'd0;
        expLo     = 32'd0;
        #12;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_busy: got %b expected 0", busy);
        end
        checks++;
        if (HI !== 32'd0 || LO !== 32'd0 || hilo_out !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reset_hilo: got HI=%h LO=%h out=%h expected 0", HI, LO, hilo_out);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_plan_vectors;
        logic [2:0]  ops [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd2, 3'd2, 3'd5, 3'd3};
        logic [31:0] as  [9] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd7, 32'h12345678,
                                 32'h55, 32'h80000000, 32'hAAAA5555, 32'hFFFFFFFF};
        logic [31:0] bs  [9] = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd0, 32'd16};
        logic [31:0] oldHi;
        logic [31:0] oldLo;
        int          n;
        for (int i = 0; i < 9; i++) begin
            oldHi = expHi;
            oldLo = expLo;
            n = modelApply(ops[i], as[i], bs[i]);
            issue(ops[i], as[i], bs[i]);
            for (int k = 0; k < n; k++) begin
                checks++;
                if (busy !== 1'b1 || HI !== oldHi || LO !== oldLo) begin
                    failures++;
                    $display("[TB] FAIL plan%0d_run cyc%0d: got busy=%b HI=%h LO=%h expected busy=1 HI=%h LO=%h",
                             i, k, busy, HI, LO, oldHi, oldLo);
                end
                @(posedge clk);
                #1;
            end
            checks++;
            if (busy !== 1'b0 || HI !== expHi || LO !== expLo) begin
                failures++;
                $display("[TB] FAIL plan%0d_done: got busy=%b HI=%h LO=%h expected busy=0 HI=%h LO=%h",
                         i, busy, HI, LO, expHi, expLo);
            end
        end
    endtask

    task automatic test_busy_ignore;
        int n;
        n = modelApply(3'd0, 32'h00012345, 32'hFFFF0003);
        issue(3'd0, 32'h00012345, 32'hFFFF0003);
        start = 1'b1;
        md_op = 3'd5;
        A     = 32'd5;
        for (int k = 0; k < n; k++) begin
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("[TB] FAIL ignore_busy cyc%0d: got %b expected 1", k, busy);
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || HI !== expHi || LO !== expLo) begin
            failures++;
            $display("[TB] FAIL ignore_result: got busy=%b HI=%h LO=%h expected busy=0 HI=%h LO=%h",
                     busy, HI, LO, expHi, expLo);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || LO !== expLo) begin
            failures++;
            $display("[TB] FAIL ignore_late: got busy=%b LO=%h expected busy=0 LO=%h", busy, LO, expLo);
        end
    endtask

    task automatic test_req_block;
        logic [2:0] ops [3] = '{3'd4, 3'd0, 3'd3};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start     = 1'b1;
            req_block = 1'b1;
            md_op     = ops[i];
            A         = 32'hDEADBEEF;
            B         = 32'd3;
            @(posedge clk);
            #1;
            start     = 1'b0;
            req_block = 1'b0;
            checks++;
            if (busy !== 1'b0 || HI !== expHi || LO !== expLo) begin
                failures++;
                $display("[TB] FAIL req_block%0d: got busy=%b HI=%h LO=%h expected busy=0 HI=%h LO=%h",
                         i, busy, HI, LO, expHi, expLo);
            end
        end
    endtask

    task automatic test_hilo_sel;
        logic [31:0] oldHi;
        logic [31:0] oldLo;
        int          n;
        oldHi = expHi;
        oldLo = expLo;
        n = modelApply(3'd1, 32'hC0FFEE11, 32'h00ABCDEF);
        issue(3'd1, 32'hC0FFEE11, 32'h00ABCDEF);
        for (int k = 0; k < n; k++) begin
            hilo_sel = (k % 2 == 1);
            #1;
            checks++;
            if (hilo_out !== (hilo_sel ? oldHi : oldLo)) begin
                failures++;
                $display("[TB] FAIL sel_run cyc%0d: got %h expected %h", k, hilo_out, hilo_sel ? oldHi : oldLo);
            end
            @(posedge clk);
            #1;
        end
        hilo_sel = 1'b1;
        #1;
        checks++;
        if (hilo_out !== expHi) begin
            failures++;
            $display("[TB] FAIL sel_hi: got %h expected %h", hilo_out, expHi);
        end
        hilo_sel = 1'b0;
        #1;
        checks++;
        if (hilo_out !== expLo) begin
            failures++;
            $display("[TB] FAIL sel_lo: got %h expected %h", hilo_out, expLo);
        end
    endtask

    task automatic test_reset_mid_run;
        issue(3'd4, 32'h0BADF00D, 32'd0);
        issue(3'd5, 32'h00C0FFEE, 32'd0);
        issue(3'd2, 32'h00001000, 32'd7);
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0 || hilo_out !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reset_async: got busy=%b HI=%h LO=%h out=%h expected all 0",
                     busy, HI, LO, hilo_out);
        end
        #2;
        reset = 1'b1;
        expHi = 32'd0;
        expLo = 32'd0;
        repeat (DIV_N + 2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reset_abort: got busy=%b HI=%h LO=%h expected busy=0 HI=0 LO=0", busy, HI, LO);
        end
    endtask

    task automatic test_random;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] oldHi;
        logic [31:0] oldLo;
        int          n;
        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) begin
                b = b >> $urandom_range(8, 31);
            end
            oldHi = expHi;
            oldLo = expLo;
            n = modelApply(op, a, b);
            issue(op, a, b);
            req_block = 1'($urandom_range(0, 1));
            for (int k = 0; k < n; k++) begin
                checks++;
                if (busy !== 1'b1 || HI !== oldHi || LO !== oldLo) begin
                    failures++;
                    $display("[TB] FAIL rand%0d_run cyc%0d op%0d: got busy=%b HI=%h LO=%h expected busy=1 HI=%h LO=%h",
                             i, k, op, busy, HI, LO, oldHi, oldLo);
                end
                @(posedge clk);
                #1;
            end
            req_block = 1'b0;
            hilo_sel  = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (busy !== 1'b0 || HI !== expHi || LO !== expLo || hilo_out !== (hilo_sel ? expHi : expLo)) begin
                failures++;
                $display("[TB] FAIL rand%0d_done op%0d a=%h b=%h: got busy=%b HI=%h LO=%h out=%h expected busy=0 HI=%h LO=%h",
                         i, op, a, b, busy, HI, LO, hilo_out, expHi, expLo);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_plan_vectors();
        test_busy_ignore();
        test_req_block();
        test_hilo_sel();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
